// File: rtl/multicycle_control_if.sv
// Signal bundle between the multi-cycle control FSM (slave) and the datapath
// that feeds it opcode/flags and consumes its mux selects and enables (master).
interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic             start_i;
  logic [5:0]       Op_i;
  logic             Zero_i;
  logic             MemAck_i;

  logic             PCWrite_o;
  logic             IRWrite_o;
  logic             IorD_o;
  logic             MemRead_o;
  logic             MemWrite_o;
  logic             ALUSrcA_o;
  logic [1:0]       ALUSrcB_o;
  logic [1:0]       ALUOp_o;
  logic [1:0]       PCSource_o;
  logic             RegWrite_o;
  logic [1:0]       RegDst_o;
  logic [1:0]       MemToReg_o;
  logic             IllegalOp_o;
  logic             Hang_o;
  logic [3:0]       State_o;
  logic [CNT_W-1:0] Retired_o;

  modport master (
    output start_i, Op_i, Zero_i, MemAck_i,
    input  PCWrite_o, IRWrite_o, IorD_o, MemRead_o, MemWrite_o,
           ALUSrcA_o, ALUSrcB_o, ALUOp_o, PCSource_o,
           RegWrite_o, RegDst_o, MemToReg_o,
           IllegalOp_o, Hang_o, State_o, Retired_o
  );

  modport slave (
    input  start_i, Op_i, Zero_i, MemAck_i,
    output PCWrite_o, IRWrite_o, IorD_o, MemRead_o, MemWrite_o,
           ALUSrcA_o, ALUSrcB_o, ALUOp_o, PCSource_o,
           RegWrite_o, RegDst_o, MemToReg_o,
           IllegalOp_o, Hang_o, State_o, Retired_o
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/memory/write-back sequencing,
// jal, memory handshake with timeout, sticky error flags and a retired counter.
module multicycle_control #(
  parameter int TIMEOUT    = 16,
  parameter bit ENABLE_JAL = 1'b1,
  parameter int CNT_W      = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  multicycle_control_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_REX    = 4'd7,
    S_RWB    = 4'd8,
    S_IEX    = 4'd9,
    S_IWB    = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_HALT   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // The wait counter holds the number of ack-less cycles already spent, so the
  // last allowed cycle is seen with the counter at TIMEOUT-1.
  localparam int TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam int WAIT_W   = (TMO_LAST < 1) ? 1 : $clog2(TMO_LAST + 1);

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       pc_write_jump;
  } ctrl_t;

  state_t            state_reg, state_next;
  ctrl_t             ctrl_reg, ctrl_next;
  logic [5:0]        op_reg, op_next;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic [CNT_W-1:0]  retired_reg;
  logic              illegal_reg;
  logic              hang_reg;
  logic              illegal_set;
  logic              retire;
  logic              wait_state;
  logic              timed_out;
  logic              ir_write;

  always_comb begin
    wait_state = (state_reg == S_FETCH) || (state_reg == S_MEMRD) || (state_reg == S_MEMWR);
    timed_out  = (TIMEOUT != 0) && wait_state && !bus.MemAck_i &&
                 (wait_cnt_reg == WAIT_W'(TMO_LAST));
  end

  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    illegal_set = 1'b0;
    retire      = 1'b0;
    case (state_reg)
      S_IDLE:   if (bus.start_i) state_next = S_FETCH;
      S_FETCH:  if (bus.MemAck_i) state_next = S_DECODE;
      S_DECODE: begin
        op_next = bus.Op_i;
        case (bus.Op_i)
          OP_RTYPE:     state_next = S_REX;
          OP_ADDI:      state_next = S_IEX;
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          OP_JAL: begin
            if (ENABLE_JAL) begin
              state_next = S_JUMP;
            end else begin
              illegal_set = 1'b1;
              state_next  = S_FETCH;
            end
          end
          default: begin
            illegal_set = 1'b1;
            state_next  = S_FETCH;
          end
        endcase
      end
      S_MEMADR: state_next = (op_reg == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (bus.MemAck_i) state_next = S_MEMWB;
      S_MEMWR: begin
        if (bus.MemAck_i) begin
          state_next = S_FETCH;
          retire     = 1'b1;
        end
      end
      S_REX:    state_next = S_RWB;
      S_IEX:    state_next = S_IWB;
      S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_IDLE;
    endcase
    // An ack in the final allowed cycle keeps timed_out low, so the ack wins.
    if (timed_out) state_next = S_HALT;
  end

  // Moore outputs are decoded from the upcoming state and registered with it.
  always_comb begin
    ctrl_next = '0;
    case (state_next)
      S_FETCH: begin
        ctrl_next.mem_read  = 1'b1;
        ctrl_next.alu_src_b = 2'b01;
      end
      S_DECODE: ctrl_next.alu_src_b = 2'b11;
      S_MEMADR, S_IEX: begin
        ctrl_next.alu_src_a = 1'b1;
        ctrl_next.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        ctrl_next.mem_read = 1'b1;
        ctrl_next.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl_next.reg_write  = 1'b1;
        ctrl_next.mem_to_reg = 2'b01;
      end
      S_MEMWR: begin
        ctrl_next.mem_write = 1'b1;
        ctrl_next.iord      = 1'b1;
      end
      S_REX: begin
        ctrl_next.alu_src_a = 1'b1;
        ctrl_next.alu_op    = 2'b10;
      end
      S_RWB: begin
        ctrl_next.reg_write = 1'b1;
        ctrl_next.reg_dst   = 2'b01;
      end
      S_IWB: ctrl_next.reg_write = 1'b1;
      S_BRANCH: begin
        ctrl_next.alu_src_a = 1'b1;
        ctrl_next.alu_op    = 2'b01;
        ctrl_next.pc_source = 2'b01;
      end
      S_JUMP: begin
        ctrl_next.pc_source     = 2'b10;
        ctrl_next.pc_write_jump = 1'b1;
        if (op_next == OP_JAL) begin
          ctrl_next.reg_write  = 1'b1;
          ctrl_next.reg_dst    = 2'b10;
          ctrl_next.mem_to_reg = 2'b10;
        end
      end
      default: ctrl_next = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg    <= S_IDLE;
      ctrl_reg     <= '0;
      op_reg       <= '0;
      wait_cnt_reg <= '0;
      retired_reg  <= '0;
      illegal_reg  <= 1'b0;
      hang_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      ctrl_reg  <= ctrl_next;
      op_reg    <= op_next;
      if (state_next != state_reg) begin
        wait_cnt_reg <= '0;
      end else if (wait_state && !bus.MemAck_i && (TIMEOUT != 0)) begin
        wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
      end
      if (retire)               retired_reg <= retired_reg + CNT_W'(1);
      if (illegal_set)          illegal_reg <= 1'b1;
      if (state_next == S_HALT) hang_reg    <= 1'b1;
    end
  end

  assign ir_write = (state_reg == S_FETCH) && bus.MemAck_i;

  assign bus.IRWrite_o   = ir_write;
  assign bus.PCWrite_o   = ir_write || ((state_reg == S_BRANCH) && bus.Zero_i) ||
                           ctrl_reg.pc_write_jump;
  assign bus.IorD_o      = ctrl_reg.iord;
  assign bus.MemRead_o   = ctrl_reg.mem_read;
  assign bus.MemWrite_o  = ctrl_reg.mem_write;
  assign bus.ALUSrcA_o   = ctrl_reg.alu_src_a;
  assign bus.ALUSrcB_o   = ctrl_reg.alu_src_b;
  assign bus.ALUOp_o     = ctrl_reg.alu_op;
  assign bus.PCSource_o  = ctrl_reg.pc_source;
  assign bus.RegWrite_o  = ctrl_reg.reg_write;
  assign bus.RegDst_o    = ctrl_reg.reg_dst;
  assign bus.MemToReg_o  = ctrl_reg.mem_to_reg;
  assign bus.IllegalOp_o = illegal_reg;
  assign bus.Hang_o      = hang_reg;
  assign bus.State_o     = state_reg;
  assign bus.Retired_o   = retired_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a per-cycle vector table for the main
// instruction mix plus hand-written reset, timeout and jal-disabled sequences.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, zero, ack;
  logic [5:0] op;

  always #5 clk = ~clk;

  multicycle_control_if #(.CNT_W(32)) ifa ();
  multicycle_control_if #(.CNT_W(32)) ifb ();

  assign ifa.start_i  = start;
  assign ifa.Op_i     = op;
  assign ifa.Zero_i   = zero;
  assign ifa.MemAck_i = ack;
  assign ifb.start_i  = start;
  assign ifb.Op_i     = op;
  assign ifb.Zero_i   = zero;
  assign ifb.MemAck_i = ack;

  multicycle_control #(.TIMEOUT(4), .ENABLE_JAL(1'b1), .CNT_W(32)) dut_a (
    .clk_i(clk), .rst_i(rst_n), .bus(ifa)
  );
  multicycle_control #(.TIMEOUT(0), .ENABLE_JAL(1'b0), .CNT_W(32)) dut_b (
    .clk_i(clk), .rst_i(rst_n), .bus(ifb)
  );

  // {PCWrite,IRWrite,IorD,MemRead,MemWrite,ALUSrcA}_ALUSrcB_ALUOp_PCSource_RegWrite_RegDst_MemToReg
  localparam logic [16:0] C_ZERO   = 17'b000000_00_00_00_0_00_00;
  localparam logic [16:0] C_FETCH  = 17'b000100_01_00_00_0_00_00;
  localparam logic [16:0] C_FETCHA = 17'b110100_01_00_00_0_00_00;
  localparam logic [16:0] C_DEC    = 17'b000000_11_00_00_0_00_00;
  localparam logic [16:0] C_MADR   = 17'b000001_10_00_00_0_00_00;
  localparam logic [16:0] C_MRD    = 17'b001100_00_00_00_0_00_00;
  localparam logic [16:0] C_MWB    = 17'b000000_00_00_00_1_00_01;
  localparam logic [16:0] C_MWR    = 17'b001010_00_00_00_0_00_00;
  localparam logic [16:0] C_REX    = 17'b000001_00_10_00_0_00_00;
  localparam logic [16:0] C_RWB    = 17'b000000_00_00_00_1_01_00;
  localparam logic [16:0] C_IEX    = 17'b000001_10_00_00_0_00_00;
  localparam logic [16:0] C_IWB    = 17'b000000_00_00_00_1_00_00;
  localparam logic [16:0] C_BR0    = 17'b000001_00_01_01_0_00_00;
  localparam logic [16:0] C_BR1    = 17'b100001_00_01_01_0_00_00;
  localparam logic [16:0] C_J      = 17'b100000_00_00_10_0_00_00;
  localparam logic [16:0] C_JAL    = 17'b100000_00_00_10_1_10_10;

  logic [16:0] a_ctrl, b_ctrl;
  assign a_ctrl = {ifa.PCWrite_o, ifa.IRWrite_o, ifa.IorD_o, ifa.MemRead_o, ifa.MemWrite_o,
                   ifa.ALUSrcA_o, ifa.ALUSrcB_o, ifa.ALUOp_o, ifa.PCSource_o,
                   ifa.RegWrite_o, ifa.RegDst_o, ifa.MemToReg_o};
  assign b_ctrl = {ifb.PCWrite_o, ifb.IRWrite_o, ifb.IorD_o, ifb.MemRead_o, ifb.MemWrite_o,
                   ifb.ALUSrcA_o, ifb.ALUSrcB_o, ifb.ALUOp_o, ifb.PCSource_o,
                   ifb.RegWrite_o, ifb.RegDst_o, ifb.MemToReg_o};

  typedef struct {
    logic        start;
    logic        ack;
    logic        zero;
    logic [5:0]  op;
    logic [3:0]  st;
    logic [16:0] ctrl;
    logic [31:0] ret;
    logic        ill;
    logic        hang;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;
  int   main_end;

  task automatic add(input int s, input int a, input int z, input int o, input int st,
                     input logic [16:0] c, input int r, input int il, input int h);
    vec_t v;
    v.start = (s != 0);
    v.ack   = (a != 0);
    v.zero  = (z != 0);
    v.op    = 6'(o);
    v.st    = 4'(st);
    v.ctrl  = c;
    v.ret   = 32'(r);
    v.ill   = (il != 0);
    v.hang  = (h != 0);
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      @(negedge clk);
      start = vecs[i].start;
      ack   = vecs[i].ack;
      zero  = vecs[i].zero;
      op    = vecs[i].op;
      #1;
      $display("vec %0d: state=%0d ctrl=%05h retired=%0d illegal=%0b hang=%0b",
               i, ifa.State_o, a_ctrl, ifa.Retired_o, ifa.IllegalOp_o, ifa.Hang_o);
      chk($sformatf("v%0d.state", i),   32'(ifa.State_o),     32'(vecs[i].st));
      chk($sformatf("v%0d.ctrl", i),    32'(a_ctrl),          32'(vecs[i].ctrl));
      chk($sformatf("v%0d.retired", i), ifa.Retired_o,        vecs[i].ret);
      chk($sformatf("v%0d.illegal", i), 32'(ifa.IllegalOp_o), 32'(vecs[i].ill));
      chk($sformatf("v%0d.hang", i),    32'(ifa.Hang_o),      32'(vecs[i].hang));
    end
  endtask

  task automatic clear_inputs();
    start = 1'b0;
    ack   = 1'b0;
    zero  = 1'b0;
    op    = 6'h00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before the test finished");
    $fatal(1);
  end

  initial begin
    // Main instruction mix on dut_a (TIMEOUT=4, jal enabled).
    add(1,0,0,0,     0, C_ZERO,   0,0,0);
    add(0,0,0,0,     1, C_FETCH,  0,0,0);
    add(0,0,0,0,     1, C_FETCH,  0,0,0);
    add(0,1,0,0,     1, C_FETCHA, 0,0,0);
    // lw, ack in the 4th MEMRD cycle (the last one allowed)
    add(0,0,0,'h23,  2, C_DEC,    0,0,0);
    add(0,0,0,0,     3, C_MADR,   0,0,0);
    add(0,0,0,0,     4, C_MRD,    0,0,0);
    add(0,0,0,0,     4, C_MRD,    0,0,0);
    add(0,0,0,0,     4, C_MRD,    0,0,0);
    add(0,1,0,0,     4, C_MRD,    0,0,0);
    add(0,0,0,0,     5, C_MWB,    0,0,0);
    add(0,1,0,0,     1, C_FETCHA, 1,0,0);
    // R-type
    add(0,0,0,'h00,  2, C_DEC,    1,0,0);
    add(0,0,0,0,     7, C_REX,    1,0,0);
    add(0,0,0,0,     8, C_RWB,    1,0,0);
    add(0,1,0,0,     1, C_FETCHA, 2,0,0);
    // addi
    add(0,0,0,'h08,  2, C_DEC,    2,0,0);
    add(0,0,0,0,     9, C_IEX,    2,0,0);
    add(0,0,0,0,    10, C_IWB,    2,0,0);
    add(0,1,0,0,     1, C_FETCHA, 3,0,0);
    // sw, ack in the 4th MEMWR cycle
    add(0,0,0,'h2b,  2, C_DEC,    3,0,0);
    add(0,0,0,0,     3, C_MADR,   3,0,0);
    add(0,0,0,0,     6, C_MWR,    3,0,0);
    add(0,0,0,0,     6, C_MWR,    3,0,0);
    add(0,0,0,0,     6, C_MWR,    3,0,0);
    add(0,1,0,0,     6, C_MWR,    3,0,0);
    add(0,1,0,0,     1, C_FETCHA, 4,0,0);
    // beq not taken, then taken
    add(0,0,0,'h04,  2, C_DEC,    4,0,0);
    add(0,0,0,0,    11, C_BR0,    4,0,0);
    add(0,1,0,0,     1, C_FETCHA, 5,0,0);
    add(0,0,0,'h04,  2, C_DEC,    5,0,0);
    add(0,0,1,0,    11, C_BR1,    5,0,0);
    add(0,1,0,0,     1, C_FETCHA, 6,0,0);
    // j, then jal
    add(0,0,0,'h02,  2, C_DEC,    6,0,0);
    add(0,0,0,0,    12, C_J,      6,0,0);
    add(0,1,0,0,     1, C_FETCHA, 7,0,0);
    add(0,0,0,'h03,  2, C_DEC,    7,0,0);
    add(0,0,0,0,    12, C_JAL,    7,0,0);
    add(0,1,0,0,     1, C_FETCHA, 8,0,0);
    // undefined opcode: back to FETCH, not retired, sticky flag
    add(0,0,0,'h3f,  2, C_DEC,    8,0,0);
    add(0,0,0,0,     1, C_FETCH,  8,1,0);
    add(0,1,0,0,     1, C_FETCHA, 8,1,0);
    // R-type up to RWB, where reset is asserted by hand
    add(0,0,0,'h00,  2, C_DEC,    8,1,0);
    add(0,0,0,0,     7, C_REX,    8,1,0);
    add(0,0,0,0,     8, C_RWB,    8,1,0);
    main_end = vecs.size();
    // sw with no ack: HALT after 4 MEMWR cycles
    add(1,0,0,0,     0, C_ZERO,   0,0,0);
    add(0,1,0,0,     1, C_FETCHA, 0,0,0);
    add(0,0,0,'h2b,  2, C_DEC,    0,0,0);
    add(0,0,0,0,     3, C_MADR,   0,0,0);
    add(0,0,0,0,     6, C_MWR,    0,0,0);
    add(0,0,0,0,     6, C_MWR,    0,0,0);
    add(0,0,0,0,     6, C_MWR,    0,0,0);
    add(0,0,0,0,     6, C_MWR,    0,0,0);
    add(1,1,1,0,    13, C_ZERO,   0,0,1);
    add(0,0,0,0,    13, C_ZERO,   0,0,1);

    // Power-on reset with all inputs 0.
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset.state",   32'(ifa.State_o),     32'd0);
    chk("reset.ctrl",    32'(a_ctrl),          32'd0);
    chk("reset.retired", ifa.Retired_o,        32'd0);
    chk("reset.illegal", 32'(ifa.IllegalOp_o), 32'd0);
    chk("reset.hang",    32'(ifa.Hang_o),      32'd0);
    #1 rst_n = 1'b1;

    run_vecs(0, main_end);

    // Reset asserted in RWB takes effect without waiting for a clock edge.
    rst_n = 1'b0;
    #1;
    chk("rwb_reset.state",   32'(ifa.State_o),     32'd0);
    chk("rwb_reset.ctrl",    32'(a_ctrl),          32'd0);
    chk("rwb_reset.regwr",   32'(ifa.RegWrite_o),  32'd0);
    chk("rwb_reset.illegal", 32'(ifa.IllegalOp_o), 32'd0);
    chk("rwb_reset.retired", ifa.Retired_o,        32'd0);
    clear_inputs();
    repeat (2) @(negedge clk);
    #1;
    chk("rwb_reset.held_state", 32'(ifa.State_o), 32'd0);
    #1 rst_n = 1'b1;

    run_vecs(main_end, vecs.size());

    // Reset clears the sticky hang flag; then jal on the jal-disabled, no-timeout copy.
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    #1;
    chk("halt_reset.hang",  32'(ifa.Hang_o),  32'd0);
    chk("halt_reset.state", 32'(ifa.State_o), 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    #1 chk("nojal.idle", 32'(ifb.State_o), 32'd0);
    @(negedge clk);
    start = 1'b0;
    ack   = 1'b1;
    #1 chk("nojal.fetch", 32'(ifb.State_o), 32'd1);
    @(negedge clk);
    ack = 1'b0;
    op  = 6'h03;
    #1;
    chk("nojal.decode",         32'(ifb.State_o),     32'd2);
    chk("nojal.illegal_before", 32'(ifb.IllegalOp_o), 32'd0);
    @(negedge clk);
    op = 6'h00;
    #1;
    $display("jal: a.state=%0d b.state=%0d b.illegal=%0b", ifa.State_o, ifb.State_o, ifb.IllegalOp_o);
    chk("nojal.back_to_fetch", 32'(ifb.State_o),     32'd1);
    chk("nojal.illegal",       32'(ifb.IllegalOp_o), 32'd1);
    chk("nojal.retired",       ifb.Retired_o,        32'd0);
    chk("nojal.fetch_ctrl",    32'(b_ctrl),          32'(C_FETCH));
    chk("jal_on.state",        32'(ifa.State_o),     32'd12);
    chk("jal_on.ctrl",         32'(a_ctrl),          32'(C_JAL));
    // Long ack-less FETCH: the TIMEOUT=0 copy waits forever, the TIMEOUT=4 copy halts.
    repeat (20) @(negedge clk);
    #1;
    $display("wait: a.state=%0d a.hang=%0b b.state=%0d b.hang=%0b",
             ifa.State_o, ifa.Hang_o, ifb.State_o, ifb.Hang_o);
    chk("notimeout.state", 32'(ifb.State_o), 32'd1);
    chk("notimeout.hang",  32'(ifb.Hang_o),  32'd0);
    chk("fetch_tmo.state", 32'(ifa.State_o), 32'd13);
    chk("fetch_tmo.hang",  32'(ifa.Hang_o),  32'd1);
    chk("fetch_tmo.ctrl",  32'(a_ctrl),      32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle MIPS control FSM that replaces the single-cycle opcode decoder in the datapath.
- Sequences each instruction through fetch, decode, execute, memory and write-back states and drives the datapath muxes and enables from the current state.
- Adds `jal`, variable-latency memory handshake with a timeout, sticky illegal-opcode and hang flags, and a retired-instruction counter.
- Sits between the instruction register / memory interface and the shared register file, ALU and PC.

## Interface
- `TIMEOUT`, 16: max cycles in any memory-wait state before hang is declared; 0 disables the timeout.
- `ENABLE_JAL`, 1: 1 decodes opcode 0x03 as `jal`; 0 treats it as illegal.
- `CNT_W`, 32: width of the retired-instruction counter.

Ports:
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: asynchronous, active-low reset.
- `start_i` in 1: begin execution; sampled only in IDLE.
- `Op_i` in 6: opcode field from the instruction register.
- `Zero_i` in 1: ALU zero flag.
- `MemAck_i` in 1: memory completes the current read/write this cycle.
- `PCWrite_o` out 1: PC write enable.
- `IRWrite_o` out 1: instruction register write enable.
- `IorD_o` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `MemRead_o`, `MemWrite_o` out 1 each: memory strobes, held until ack.
- `ALUSrcA_o` out 1: ALU A select. 0 = PC, 1 = rs.
- `ALUSrcB_o` out 2: ALU B select. 00 = rt, 01 = 4, 10 = sign-extended immediate, 11 = immediate<<2.
- `ALUOp_o` out 2: 00 add, 01 sub, 10 use funct.
- `PCSource_o` out 2: 00 ALU result, 01 ALUOut, 10 jump target.
- `RegWrite_o` out 1: register file write enable.
- `RegDst_o` out 2: destination select. 00 rt, 01 rd, 10 $31.
- `MemToReg_o` out 2: write-back data select. 00 ALUOut, 01 MDR, 10 PC.
- `IllegalOp_o` out 1: sticky; an undefined opcode was decoded.
- `Hang_o` out 1: sticky; a memory timeout occurred.
- `State_o` out 4: current state encoding.
- `Retired_o` out CNT_W: count of completed instructions.

## Operation
State encodings: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, REX 7, RWB 8, IEX 9, IWB 10, BRANCH 11, JUMP 12, HALT 13.
- Every control output not listed for a state is 0.
- IDLE: go to FETCH when `start_i`=1.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=PCWrite=`MemAck_i` (combinational).
  - On ack, go to DECODE; otherwise stay.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Dispatch on `Op_i`:
  - 0x00 → REX
  - 0x08 → IEX
  - 0x23 or 0x2b → MEMADR
  - 0x04 → BRANCH
  - 0x02 → JUMP
  - 0x03 → JUMP if `ENABLE_JAL`=1
  - Anything else: set `IllegalOp_o`, go to FETCH; the instruction is not counted as retired.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEMRD for lw, MEMWR for sw; the opcode is latched in DECODE.
- MEMRD: MemRead=1, IorD=1. On ack, go to MEMWB.
- MEMWB: RegWrite=1, RegDst=00, MemToReg=01. Go to FETCH.
- MEMWR: MemWrite=1, IorD=1. On ack, go to FETCH.
- REX: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to RWB.
- RWB: RegWrite=1, RegDst=01, MemToReg=00. Go to FETCH.
- IEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to IWB.
- IWB: RegWrite=1, RegDst=00, MemToReg=00. Go to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, PCWrite=`Zero_i`. Go to FETCH.
- JUMP: PCSource=10, PCWrite=1. For `jal` additionally RegWrite=1, RegDst=10, MemToReg=10. Go to FETCH.
- HALT: all control outputs 0 and `Hang_o`=1. Left only by reset.
- `Retired_o` increments by 1 on every transition from MEMWB, MEMWR, RWB, IWB, BRANCH or JUMP to FETCH. It wraps modulo 2^CNT_W.

## Timing
- Reset (async, `rst_i`=0):
  - State=IDLE.
  - All outputs 0, including the sticky flags and `Retired_o`.
  - Reset asserted mid-instruction aborts it immediately, with no write enables after the reset edge.
- Wait counter:
  - Cleared on entry to FETCH, MEMRD or MEMWR.
  - Increments each cycle in that state without ack.
  - Ack in cycle k (1..TIMEOUT) is accepted.
  - No ack by the end of cycle TIMEOUT: go to HALT on the next edge.
  - Ack and timeout coinciding in cycle TIMEOUT: the ack wins.
- Cycle counts with zero-wait memory (ack in the first cycle of each wait state):
  - R-type 4, addi 4, lw 5, sw 4, beq 3, j/jal 3.
  - Each cycle without ack adds 1.
- State outputs are Moore, registered from state. The only Mealy terms are the FETCH IRWrite/PCWrite (from `MemAck_i`) and the BRANCH PCWrite (from `Zero_i`).
- `Op_i` is sampled only in DECODE; it may change in any other state.

## Test plan
- Reset with all inputs 0, then `start_i`=1 for one cycle → IDLE→FETCH; FETCH outputs MemRead=1 until ack; `Retired_o`=0.
- lw (0x23) with ack delayed 3 cycles in MEMRD → states 1,2,3,4,4,4,4,5,1; RegWrite=1 with MemToReg=01 only in MEMWB; `Retired_o`=1.
- beq with `Zero_i`=0, then with `Zero_i`=1 → PCWrite 0 and then 1 in BRANCH; PCSource=01 in both.
- jal with ENABLE_JAL=1 → JUMP drives RegDst=10, MemToReg=10, RegWrite=1, PCWrite=1. With ENABLE_JAL=0 the same opcode sets `IllegalOp_o`=1, returns to FETCH, and `Retired_o` is unchanged.
- TIMEOUT=4 with no ack in MEMWR → HALT after 4 cycles; `Hang_o`=1 and all control outputs stay 0. Ack arriving in cycle 4 instead is accepted, with no HALT.
- Assert `rst_i`=0 while in RWB → outputs 0 immediately, State_o=0; the sticky flags are cleared.
